// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling and bubble count.
// Optional define ID_EX_WB_BYPASS_EN bypasses WB write data into the captured operands.
module id_ex_stage #(
    parameter int unsigned DW   = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [DW-1:0]   id_pc_i,
    input  logic [DW-1:0]   rs_data_i,
    input  logic [DW-1:0]   rt_data_i,
    input  logic [DW-1:0]   imm_i,
    input  logic [4:0]      rs_addr_i,
    input  logic [4:0]      rt_addr_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            reg_write_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            mem_to_reg_i,
    input  logic            alu_src_i,
    input  logic            reg_dst_i,
    input  logic [1:0]      alu_op_i,
    input  logic            wb_reg_write_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [DW-1:0]   wb_data_i,
    output logic [DW-1:0]   ex_pc_o,
    output logic [DW-1:0]   ex_rs_data_o,
    output logic [DW-1:0]   ex_rt_data_o,
    output logic [DW-1:0]   ex_imm_o,
    output logic [4:0]      ex_rs_addr_o,
    output logic [4:0]      ex_rt_addr_o,
    output logic [4:0]      ex_rd_addr_o,
    output logic            ex_reg_write_o,
    output logic            ex_mem_read_o,
    output logic            ex_mem_write_o,
    output logic            ex_mem_to_reg_o,
    output logic            ex_alu_src_o,
    output logic            ex_reg_dst_o,
    output logic [1:0]      ex_alu_op_o,
    output logic            ex_valid_o,
    output logic            hazard_o,
    output logic [CNTW-1:0] bubble_cnt_o
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    rs_addr;
        logic [4:0]    rt_addr;
        logic [4:0]    rd_addr;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          alu_src;
        logic          reg_dst;
        logic [1:0]    alu_op;
    } ex_t;

    ex_t            ex_d, ex_q;
    logic [CNTW-1:0] cnt_d, cnt_q;
    logic [DW-1:0]  rs_fwd, rt_fwd;
    logic           hazard;

    // rt is always compared, even for instructions that do not read it.
    assign hazard = ex_q.valid & ex_q.mem_read & id_valid_i & (ex_q.rt_addr != 5'd0) &
                    ((ex_q.rt_addr == rs_addr_i) | (ex_q.rt_addr == rt_addr_i));

`ifdef ID_EX_WB_BYPASS_EN
    always_comb begin
        rs_fwd = rs_data_i;
        rt_fwd = rt_data_i;
        if (wb_reg_write_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs_addr_i)) rs_fwd = wb_data_i;
        if (wb_reg_write_i && (wb_addr_i != 5'd0) && (wb_addr_i == rt_addr_i)) rt_fwd = wb_data_i;
    end
`else
    // Register file writes on the falling edge, so read data is already current.
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write_i, wb_addr_i, wb_data_i};
    assign rs_fwd    = rs_data_i;
    assign rt_fwd    = rt_data_i;
`endif

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (!stall_i) begin
            if (flush_i) begin
                ex_d = '0;
            end else if (hazard) begin
                ex_d = '0;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else begin
                ex_d.valid      = id_valid_i;
                ex_d.pc         = id_pc_i;
                ex_d.rs_data    = rs_fwd;
                ex_d.rt_data    = rt_fwd;
                ex_d.imm        = imm_i;
                ex_d.rs_addr    = rs_addr_i;
                ex_d.rt_addr    = rt_addr_i;
                ex_d.rd_addr    = rd_addr_i;
                ex_d.reg_write  = reg_write_i;
                ex_d.mem_read   = mem_read_i;
                ex_d.mem_write  = mem_write_i;
                ex_d.mem_to_reg = mem_to_reg_i;
                ex_d.alu_src    = alu_src_i;
                ex_d.reg_dst    = reg_dst_i;
                ex_d.alu_op     = alu_op_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid_o      = ex_q.valid;
    assign ex_pc_o         = ex_q.pc;
    assign ex_rs_data_o    = ex_q.rs_data;
    assign ex_rt_data_o    = ex_q.rt_data;
    assign ex_imm_o        = ex_q.imm;
    assign ex_rs_addr_o    = ex_q.rs_addr;
    assign ex_rt_addr_o    = ex_q.rt_addr;
    assign ex_rd_addr_o    = ex_q.rd_addr;
    assign ex_reg_write_o  = ex_q.reg_write;
    assign ex_mem_read_o   = ex_q.mem_read;
    assign ex_mem_write_o  = ex_q.mem_write;
    assign ex_mem_to_reg_o = ex_q.mem_to_reg;
    assign ex_alu_src_o    = ex_q.alu_src;
    assign ex_reg_dst_o    = ex_q.reg_dst;
    assign ex_alu_op_o     = ex_q.alu_op;
    assign hazard_o        = hazard;
    assign bubble_cnt_o    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model compared every cycle plus literal checks.
// A second instance with a 4-bit counter exercises counter saturation within a short run.
module tb_id_ex_stage;

`ifdef ID_EX_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic [1:0]  alu_op;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [31:0] id_pc = '0, rs_data = '0, rt_data = '0, imm = '0, wb_data = '0;
    logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0, wb_addr = '0;
    logic        reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
    logic        alu_src = 1'b0, reg_dst = 1'b0, wb_we = 1'b0;
    logic [1:0]  alu_op = '0;

    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
    logic [1:0]  ex_alu_op;
    logic        ex_valid, hazard;
    logic [15:0] cnt;

    logic [31:0] s_pc, s_rs_data, s_rt_data, s_imm;
    logic [4:0]  s_rs_addr, s_rt_addr, s_rd_addr;
    logic        s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg, s_alu_src, s_reg_dst;
    logic [1:0]  s_alu_op;
    logic        s_valid, s_hazard;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
        .id_pc_i(id_pc), .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_i(imm),
        .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
        .reg_write_i(reg_write), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .mem_to_reg_i(mem_to_reg), .alu_src_i(alu_src), .reg_dst_i(reg_dst), .alu_op_i(alu_op),
        .wb_reg_write_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .ex_pc_o(ex_pc), .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data), .ex_imm_o(ex_imm),
        .ex_rs_addr_o(ex_rs_addr), .ex_rt_addr_o(ex_rt_addr), .ex_rd_addr_o(ex_rd_addr),
        .ex_reg_write_o(ex_reg_write), .ex_mem_read_o(ex_mem_read),
        .ex_mem_write_o(ex_mem_write), .ex_mem_to_reg_o(ex_mem_to_reg),
        .ex_alu_src_o(ex_alu_src), .ex_reg_dst_o(ex_reg_dst), .ex_alu_op_o(ex_alu_op),
        .ex_valid_o(ex_valid), .hazard_o(hazard), .bubble_cnt_o(cnt)
    );

    id_ex_stage #(.DW(32), .CNTW(4)) u_sat (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
        .id_pc_i(id_pc), .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_i(imm),
        .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
        .reg_write_i(reg_write), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .mem_to_reg_i(mem_to_reg), .alu_src_i(alu_src), .reg_dst_i(reg_dst), .alu_op_i(alu_op),
        .wb_reg_write_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .ex_pc_o(s_pc), .ex_rs_data_o(s_rs_data), .ex_rt_data_o(s_rt_data), .ex_imm_o(s_imm),
        .ex_rs_addr_o(s_rs_addr), .ex_rt_addr_o(s_rt_addr), .ex_rd_addr_o(s_rd_addr),
        .ex_reg_write_o(s_reg_write), .ex_mem_read_o(s_mem_read),
        .ex_mem_write_o(s_mem_write), .ex_mem_to_reg_o(s_mem_to_reg),
        .ex_alu_src_o(s_alu_src), .ex_reg_dst_o(s_reg_dst), .ex_alu_op_o(s_alu_op),
        .ex_valid_o(s_valid), .hazard_o(s_hazard), .bubble_cnt_o(s_cnt)
    );

    // Reference model: expected EX contents and bubble counts.
    ex_t m = '0;
    int  mcnt = 0;
    int  msat = 0;

    function automatic logic model_hazard();
        return m.valid && m.mem_read && id_valid && (m.rt_addr != 0) &&
               (m.rt_addr == rs_addr || m.rt_addr == rt_addr);
    endfunction

    function automatic ex_t model_capture();
        ex_t c;
        c.valid      = id_valid;
        c.pc         = id_pc;
        c.rs_data    = (BYP && wb_we && wb_addr != 0 && wb_addr == rs_addr) ? wb_data : rs_data;
        c.rt_data    = (BYP && wb_we && wb_addr != 0 && wb_addr == rt_addr) ? wb_data : rt_data;
        c.imm        = imm;
        c.rs_addr    = rs_addr;
        c.rt_addr    = rt_addr;
        c.rd_addr    = rd_addr;
        c.reg_write  = reg_write;
        c.mem_read   = mem_read;
        c.mem_write  = mem_write;
        c.mem_to_reg = mem_to_reg;
        c.alu_src    = alu_src;
        c.reg_dst    = reg_dst;
        c.alu_op     = alu_op;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m    <= '0;
            mcnt <= 0;
            msat <= 0;
        end else if (stall) begin
            m <= m;
        end else if (flush) begin
            m <= '0;
        end else if (model_hazard()) begin
            m    <= '0;
            mcnt <= (mcnt < 65535) ? mcnt + 1 : mcnt;
            msat <= (msat < 15) ? msat + 1 : msat;
        end else begin
            m <= model_capture();
        end
    end

    task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    ex_t dut_v;
    assign dut_v = {ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs_addr, ex_rt_addr,
                    ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                    ex_alu_src, ex_reg_dst, ex_alu_op};

    always @(negedge clk) begin
        chk("ex_fields", dut_v, m);
        chk("hazard", 152'(hazard), 152'(model_hazard()));
        chk("bubble_cnt", 152'(cnt), 152'(mcnt));
        chk("sat_cnt", 152'(s_cnt), 152'(msat));
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic ld);
        id_valid   = v;
        id_pc      = pc;
        rs_addr    = rs;
        rt_addr    = rt;
        rd_addr    = rd;
        mem_read   = ld;
        mem_to_reg = ld;
        alu_src    = ld;
        reg_write  = 1'b1;
        reg_dst    = ~ld;
        alu_op     = ld ? 2'd0 : 2'd2;
        rs_data    = {27'd0, rs} + 32'h100;
        rt_data    = {27'd0, rt} + 32'h200;
        imm        = ld ? 32'h0000_0010 : 32'h0;
    endtask

    initial begin
        repeat (2) edge1();
        #1;
        chk("reset_valid", 152'(ex_valid), 152'(0));
        chk("reset_pc", 152'(ex_pc), 152'(0));
        chk("reset_cnt", 152'(cnt), 152'(0));
        rst_n = 1'b1;

        // Plain capture.
        edge1();
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b0);
        rs_data = 32'h0000_1234;
        imm     = 32'hFFFF_FFF0;
        edge1();
        chk("cap_rs_data", 152'(ex_rs_data), 152'(32'h1234));
        chk("cap_imm", 152'(ex_imm), 152'(32'hFFFF_FFF0));
        chk("cap_valid", 152'(ex_valid), 152'(1));

        // Load-use on rs: lw r8 then consumer of r8.
        set_id(1'b1, 32'h104, 5'd9, 5'd8, 5'd0, 1'b1);
        edge1();
        set_id(1'b1, 32'h108, 5'd8, 5'd10, 5'd11, 1'b0);
        rs_data = 32'h55;
        #1;
        chk("lu_hazard", 152'(hazard), 152'(1));
        edge1();
        chk("lu_bubble_valid", 152'(ex_valid), 152'(0));
        chk("lu_cnt", 152'(cnt), 152'(1));
        chk("lu_hazard_drop", 152'(hazard), 152'(0));
        edge1();
        chk("lu_dep_valid", 152'(ex_valid), 152'(1));
        chk("lu_dep_rs_data", 152'(ex_rs_data), 152'(32'h55));

        // Load to r0 never stalls; load-use through rt does.
        set_id(1'b1, 32'h10C, 5'd9, 5'd0, 5'd0, 1'b1);
        edge1();
        set_id(1'b1, 32'h110, 5'd0, 5'd0, 5'd4, 1'b0);
        #1;
        chk("r0_hazard", 152'(hazard), 152'(0));
        edge1();
        chk("r0_cnt", 152'(cnt), 152'(1));
        set_id(1'b1, 32'h114, 5'd9, 5'd12, 5'd0, 1'b1);
        edge1();
        set_id(1'b1, 32'h118, 5'd3, 5'd12, 5'd4, 1'b0);
        #1;
        chk("rt_hazard", 152'(hazard), 152'(1));
        id_valid = 1'b0;
        #1;
        chk("invalid_id_hazard", 152'(hazard), 152'(0));
        id_valid = 1'b1;
        edge1();
        chk("rt_cnt", 152'(cnt), 152'(2));
        edge1();

        // Flush together with a hazard: one bubble, no count.
        set_id(1'b1, 32'h120, 5'd9, 5'd8, 5'd0, 1'b1);
        edge1();
        set_id(1'b1, 32'h124, 5'd8, 5'd1, 5'd2, 1'b0);
        flush = 1'b1;
        edge1();
        flush = 1'b0;
        chk("flush_valid", 152'(ex_valid), 152'(0));
        chk("flush_cnt", 152'(cnt), 152'(2));
        edge1();

        // Stall for 3 cycles with a pending hazard and changing ID.
        set_id(1'b1, 32'h200, 5'd9, 5'd8, 5'd0, 1'b1);
        edge1();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 32'h300 + 32'(i), 5'd8, 5'(i), 5'd7, 1'b0);
            edge1();
            chk("stall_pc", 152'(ex_pc), 152'(32'h200));
        end
        chk("stall_cnt", 152'(cnt), 152'(2));
        stall = 1'b0;
        edge1();
        chk("post_stall_cnt", 152'(cnt), 152'(3));

        // Back-to-back self-dependent loads: one bubble every other edge.
        set_id(1'b1, 32'h400, 5'd8, 5'd8, 5'd0, 1'b1);
        repeat (40) edge1();
        chk("many_cnt", 152'(cnt), 152'(23));
        chk("sat_cnt_lit", 152'(s_cnt), 152'(15));

        // WB bypass: {wb_we, wb_addr, rs_addr, rt_addr}.
        stall = 1'b0;
        set_id(1'b1, 32'h500, 5'd5, 5'd6, 5'd7, 1'b0);
        rs_data = 32'h0;
        rt_data = 32'h77;
        wb_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_rs, exp_rt;
            wb_we   = (i != 3);
            wb_addr = (i == 1) ? 5'd0 : (i == 2) ? 5'd6 : 5'd5;
            exp_rs  = (BYP && i == 0) ? 32'hDEAD_BEEF : 32'h0;
            exp_rt  = (BYP && i == 2) ? 32'hDEAD_BEEF : 32'h77;
            edge1();
            chk("byp_rs", 152'(ex_rs_data), 152'(exp_rs));
            chk("byp_rt", 152'(ex_rt_data), 152'(exp_rt));
        end
        wb_we = 1'b0;

        // Asynchronous reset between edges.
        set_id(1'b1, 32'h600, 5'd1, 5'd2, 5'd3, 1'b0);
        edge1();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 152'(ex_valid), 152'(0));
        chk("async_pc", 152'(ex_pc), 152'(0));
        chk("async_cnt", 152'(cnt), 152'(0));
        edge1();
        rst_n = 1'b1;
        edge1();
        chk("post_reset_pc", 152'(ex_pc), 152'(32'h600));
        repeat (2) edge1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
